frame_mode_sequencer: RTL and testbench

Top-level pipeline controller in the 125 MHz processing domain. Sequences camera configuration at power-up. Changes Gaussian filter enable only at frame boundaries, using a flush/drain handshake so the camera output buffer, the filter and the frame-buffer writer never see a mid-frame mode change. Drives the cfg_start, gaussian_enable and pipe_flush nets consumed by the camera block, filter and memory interface.

---
 rtl/frame_mode_sequencer_pkg.sv | 22 ++
 rtl/frame_mode_sequencer_switch_sync_stable.sv | 44 ++++
 rtl/frame_mode_sequencer.sv | 128 ++++++++++++
 tb/tb_frame_mode_sequencer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_mode_sequencer_pkg.sv
// Shared definitions for the frame mode sequencer: state codes and parameter defaults.
package frame_mode_sequencer_pkg;

    localparam int unsigned STATE_W = 3;

    localparam int unsigned FLUSH_CYCLES_DEF  = 16;
    localparam int unsigned SW_STABLE_DEF     = 1250000;
    localparam int unsigned DRAIN_TIMEOUT_DEF = 65535;
    localparam int unsigned CNT_W_DEF         = 21;

    typedef enum logic [STATE_W-1:0] {
        ST_INIT     = 3'd0,
        ST_CFG      = 3'd1,
        ST_CFG_WAIT = 3'd2,
        ST_SOF_WAIT = 3'd3,
        ST_RUN      = 3'd4,
        ST_ARM      = 3'd5,
        ST_FLUSH    = 3'd6,
        ST_DRAIN    = 3'd7
    } fms_state_t;

endpackage

// File: rtl/frame_mode_sequencer_switch_sync_stable.sv
// Board switch conditioner: 2-FF synchronizer followed by a stability filter.
module switch_sync_stable #(
    parameter int unsigned SW_STABLE = 1250000,
    parameter int unsigned CNT_W     = 21
) (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_sw,
    output logic o_level,
    output logic o_change
);

    logic             sync_q1;
    logic             sync_q2;
    logic             sync_prev;
    logic [CNT_W-1:0] stab_cnt;

    // Synchronize, then accept a new level only after it has held for SW_STABLE cycles.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            sync_q1   <= 1'b0;
            sync_q2   <= 1'b0;
            sync_prev <= 1'b0;
            stab_cnt  <= '0;
            o_level   <= 1'b0;
            o_change  <= 1'b0;
        end else begin
            sync_q1   <= i_sw;
            sync_q2   <= sync_q1;
            sync_prev <= sync_q2;
            o_change  <= 1'b0;
            if ((sync_q2 == o_level) || (sync_q2 != sync_prev)) begin
                stab_cnt <= '0;
            end else if (stab_cnt == CNT_W'(SW_STABLE - 1)) begin
                o_level  <= sync_q2;
                o_change <= 1'b1;
                stab_cnt <= '0;
            end else begin
                stab_cnt <= stab_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/frame_mode_sequencer.sv
// Frame-boundary mode sequencer: camera config at power-up, flush/drain-guarded filter enable changes.
module frame_mode_sequencer
    import frame_mode_sequencer_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES  = FLUSH_CYCLES_DEF,
    parameter int unsigned SW_STABLE     = SW_STABLE_DEF,
    parameter int unsigned DRAIN_TIMEOUT = DRAIN_TIMEOUT_DEF,
    parameter int unsigned CNT_W         = CNT_W_DEF
) (
    input  logic               i_clk,
    input  logic               i_rstn,
    input  logic               i_sof,
    input  logic               i_cfg_done,
    input  logic               i_sw_gaussian,
    input  logic               i_cam_empty,
    input  logic               i_lpf_empty,
    output logic               o_cfg_start,
    output logic               o_gaussian_enable,
    output logic               o_pipe_flush,
    output logic               o_busy,
    output logic               o_error,
    output logic [STATE_W-1:0] o_state
);

    fms_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pending_q, pending_d;
    logic             gauss_d, error_d, cfg_start_d, flush_d, busy_d;
    logic             sw_level;
    logic             sw_change;

    switch_sync_stable #(
        .SW_STABLE (SW_STABLE),
        .CNT_W     (CNT_W)
    ) u_sw (
        .i_clk    (i_clk),
        .i_rstn   (i_rstn),
        .i_sw     (i_sw_gaussian),
        .o_level  (sw_level),
        .o_change (sw_change)
    );

    // Next state, counter, pending flag and next registered output values.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pending_d = pending_q;
        gauss_d   = o_gaussian_enable;
        error_d   = o_error;
        case (state_q)
            ST_INIT:     state_d = ST_CFG;
            ST_CFG:      state_d = ST_CFG_WAIT;
            ST_CFG_WAIT: if (i_cfg_done) state_d = ST_SOF_WAIT;
            ST_SOF_WAIT: begin
                if (i_sof) begin
                    gauss_d   = sw_level;
                    pending_d = 1'b0;
                    state_d   = ST_RUN;
                end
            end
            ST_RUN: begin
                if (pending_q) begin
                    pending_d = 1'b0;
                    if (sw_level != o_gaussian_enable) state_d = ST_ARM;
                end
            end
            ST_ARM: begin
                if (i_sof) begin
                    state_d = ST_FLUSH;
                    cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
                end
            end
            ST_FLUSH: begin
                if (cnt_q == '0) begin
                    state_d = ST_DRAIN;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DRAIN: begin
                if (i_cam_empty && i_lpf_empty) begin
                    gauss_d   = sw_level;
                    pending_d = 1'b0;
                    state_d   = ST_RUN;
                end else if (cnt_q == CNT_W'(DRAIN_TIMEOUT - 1)) begin
                    error_d   = 1'b1;
                    gauss_d   = sw_level;
                    pending_d = 1'b0;
                    state_d   = ST_RUN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_INIT;
        endcase
        // A new accepted switch value always re-arms the pending flag.
        if (sw_change) pending_d = 1'b1;
        cfg_start_d = (state_d == ST_CFG);
        flush_d     = (state_d == ST_FLUSH);
        busy_d      = (state_d != ST_RUN);
    end

    // State, counter and output registers.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q           <= ST_INIT;
            cnt_q             <= '0;
            pending_q         <= 1'b0;
            o_gaussian_enable <= 1'b0;
            o_error           <= 1'b0;
            o_cfg_start       <= 1'b0;
            o_pipe_flush      <= 1'b0;
            o_busy            <= 1'b0;
        end else begin
            state_q           <= state_d;
            cnt_q             <= (state_q == ST_FLUSH && state_d == ST_DRAIN) ? '0 : cnt_d;
            pending_q         <= pending_d;
            o_gaussian_enable <= gauss_d;
            o_error           <= error_d;
            o_cfg_start       <= cfg_start_d;
            o_pipe_flush      <= flush_d;
            o_busy            <= busy_d;
        end
    end

    assign o_state = state_q;

endmodule

// File: tb/tb_frame_mode_sequencer.sv
// Scoreboard bench for frame_mode_sequencer: stimulus queues expected events, monitor checks them.
module tb_frame_mode_sequencer;

    localparam int unsigned FLUSH_CYCLES  = 3;
    localparam int unsigned SW_STABLE     = 4;
    localparam int unsigned DRAIN_TIMEOUT = 40;
    localparam int unsigned CNT_W         = 8;

    localparam int S_INIT = 0, S_CFG = 1, S_CFG_WAIT = 2, S_SOF_WAIT = 3;
    localparam int S_RUN = 4, S_ARM = 5, S_FLUSH = 6, S_DRAIN = 7;

    localparam int EV_CFG = 0, EV_FLUSH = 1, EV_EN = 2, EV_ERR = 3, EV_DRAIN = 4;

    typedef struct {
        int kind;
        int value;
    } ev_t;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       sof = 1'b0;
    logic       cfg_done = 1'b0;
    logic       sw = 1'b0;
    logic       cam_empty = 1'b1;
    logic       lpf_empty = 1'b1;
    logic       cfg_start, gauss_en, pipe_flush, busy, error;
    logic [2:0] state;

    int  n_pass = 0;
    int  n_total = 0;
    bit  mon_en = 1'b0;
    ev_t exp_q[$];

    // Reference model: accepted switch level, applied enable, sticky error.
    int m_acc = 0;
    int m_en = 0;
    int m_err = 0;

    frame_mode_sequencer #(
        .FLUSH_CYCLES  (FLUSH_CYCLES),
        .SW_STABLE     (SW_STABLE),
        .DRAIN_TIMEOUT (DRAIN_TIMEOUT),
        .CNT_W         (CNT_W)
    ) dut (
        .i_clk             (clk),
        .i_rstn            (rstn),
        .i_sof             (sof),
        .i_cfg_done        (cfg_done),
        .i_sw_gaussian     (sw),
        .i_cam_empty       (cam_empty),
        .i_lpf_empty       (lpf_empty),
        .o_cfg_start       (cfg_start),
        .o_gaussian_enable (gauss_en),
        .o_pipe_flush      (pipe_flush),
        .o_busy            (busy),
        .o_error           (error),
        .o_state           (state)
    );

    always #4 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic push(input int kind, input int value);
        ev_t e;
        e.kind  = kind;
        e.value = value;
        exp_q.push_back(e);
    endtask

    task automatic emit(input int kind, input int value);
        ev_t e;
        n_total++;
        if (exp_q.size() == 0) begin
            $display("FAIL unexpected_event: got kind %0d value %0d expected none at %0t", kind, value, $time);
        end else begin
            e = exp_q.pop_front();
            if (e.kind == kind && e.value == value) n_pass++;
            else $display("FAIL event: got kind %0d value %0d expected kind %0d value %0d at %0t",
                          kind, value, e.kind, e.value, $time);
        end
    endtask

    // Monitor: turns output activity into events and compares against the queue.
    initial begin : monitor
        int p_en = 0, p_err = 0, l_cfg = 0, l_flush = 0, l_drain = 0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (int'(error) != p_err) begin emit(EV_ERR, int'(error)); p_err = int'(error); end
                if (int'(gauss_en) != p_en) begin emit(EV_EN, int'(gauss_en)); p_en = int'(gauss_en); end
                if (int'(state) == S_DRAIN) l_drain++;
                else if (l_drain > 0) begin emit(EV_DRAIN, l_drain); l_drain = 0; end
                if (pipe_flush) l_flush++;
                else if (l_flush > 0) begin emit(EV_FLUSH, l_flush); l_flush = 0; end
                if (cfg_start) l_cfg++;
                else if (l_cfg > 0) begin emit(EV_CFG, l_cfg); l_cfg = 0; end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_state(input int s, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (int'(state) == s) break;
        end
        check("wait_state", int'(state), s);
    endtask

    task automatic pulse_sof();
        sof = 1'b1;
        tick(1);
        sof = 1'b0;
    endtask

    task automatic apply_model();
        if (m_acc != m_en) push(EV_EN, m_acc);
        m_en = m_acc;
    endtask

    // Release reset and walk the configuration sequence into RUN.
    task automatic power_up();
        push(EV_CFG, 1);
        rstn = 1'b1;
        wait_state(S_CFG, 3);
        check("cfg_start_in_cfg", int'(cfg_start), 1);
        check("busy_in_cfg", int'(busy), 1);
        wait_state(S_CFG_WAIT, 3);
        tick(50);
        check("cfg_wait_hold", int'(state), S_CFG_WAIT);
        cfg_done = 1'b1;
        wait_state(S_SOF_WAIT, 4);
        m_acc = int'(sw);
        pulse_sof();
        apply_model();
        wait_state(S_RUN, 4);
        check("run_enable", int'(gauss_en), m_en);
        check("run_busy", int'(busy), 0);
    endtask

    // Flip the switch and carry the change through ARM/FLUSH/DRAIN. mode 0: empties ready,
    // 1: filter busy for n cycles, 2: camera never empties (timeout), 3: switch returns in drain.
    task automatic mode_change(input int mode, input int n);
        int old_acc = m_acc;
        sw = ~sw;
        tick(2);
        check("no_early_change", int'(state), S_RUN);
        tick(10);
        m_acc = int'(sw);
        wait_state(S_ARM, 10);
        check("arm_busy", int'(busy), 1);
        if (mode == 1 || mode == 3) lpf_empty = 1'b0;
        if (mode == 2) cam_empty = 1'b0;
        tick($urandom_range(0, 5));
        check("arm_waits_sof", int'(state), S_ARM);
        push(EV_FLUSH, int'(FLUSH_CYCLES));
        pulse_sof();
        wait_state(S_DRAIN, 10);
        if (mode == 3) begin
            sw = ~sw;
            m_acc = old_acc;
        end
        if (mode == 1 || mode == 3) begin
            tick(n);
            lpf_empty = 1'b1;
        end
        if (mode == 2 && m_err == 0) begin
            push(EV_ERR, 1);
            m_err = 1;
        end
        apply_model();
        push(EV_DRAIN, (mode == 0) ? 1 : (mode == 2) ? int'(DRAIN_TIMEOUT) : n + 1);
        wait_state(S_RUN, int'(DRAIN_TIMEOUT) + 10);
        cam_empty = 1'b1;
        check("enable_applied", int'(gauss_en), m_en);
        check("error_flag", int'(error), m_err);
        tick(12);
        check("settled_run", int'(state), S_RUN);
    endtask

    initial begin : stim
        // Reset state
        tick(3);
        check("reset_state", int'(state), S_INIT);
        check("reset_outputs", int'({cfg_start, gauss_en, pipe_flush, busy, error}), 0);
        mon_en = 1'b1;
        power_up();

        // Directed mode changes: immediate drain, 20-cycle drain wait, timeout
        mode_change(0, 0);
        mode_change(1, 20);
        mode_change(2, 0);
        check("error_sticky", int'(error), 1);

        // Bounce shorter than the stability window and stray sof in RUN
        for (int i = 0; i < 3; i++) begin
            sw = ~sw;
            tick(2);
        end
        sw = ~sw;
        tick(3);
        pulse_sof();
        tick(15);
        check("glitch_no_arm", int'(state), S_RUN);
        check("glitch_enable", int'(gauss_en), m_en);

        // Switch returns to the applied value during drain: no second flush
        mode_change(3, 20);

        // Randomized mode changes
        for (int i = 0; i < 8; i++) begin
            mode_change(int'($urandom_range(0, 2)), int'($urandom_range(1, 20)));
        end

        // Reset on the second flush cycle
        sw = ~sw;
        tick(12);
        m_acc = int'(sw);
        wait_state(S_ARM, 10);
        pulse_sof();
        for (int i = 0; i < 10; i++) begin
            if (pipe_flush) break;
            tick(1);
        end
        check("flush_seen", int'(pipe_flush), 1);
        tick(1);
        if (m_err != 0) push(EV_ERR, 0);
        if (m_en != 0) push(EV_EN, 0);
        push(EV_FLUSH, 2);
        rstn = 1'b0;
        cfg_done = 1'b0;
        m_en = 0;
        m_err = 0;
        tick(1);
        check("midflush_reset_state", int'(state), S_INIT);
        check("midflush_reset_outputs", int'({cfg_start, gauss_en, pipe_flush, busy, error}), 0);
        tick(2);
        power_up();
        mode_change(0, 0);

        tick(10);
        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
